// File: rtl/call_manager_pkg.sv
// Shared codes for the call-control engine: UI command codes, UI event
// codes, network message types and the call state enum.
package call_manager_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DIALING   = 3'd1,
    ST_RINGING   = 3'd2,
    ST_CONNECTED = 3'd3
  } call_state_e;

  localparam logic [2:0] CMD_NONE   = 3'd0;
  localparam logic [2:0] CMD_DIAL   = 3'd1;
  localparam logic [2:0] CMD_ACCEPT = 3'd2;
  localparam logic [2:0] CMD_REJECT = 3'd3;
  localparam logic [2:0] CMD_END    = 3'd4;

  localparam logic [2:0] INC_NONE      = 3'd0;
  localparam logic [2:0] INC_CONNECTED = 3'd1;
  localparam logic [2:0] INC_REFUSED   = 3'd2;
  localparam logic [2:0] INC_NO_ANSWER = 3'd3;
  localparam logic [2:0] INC_INCOMING  = 3'd5;
  localparam logic [2:0] INC_ENDED     = 3'd6;

  localparam logic [1:0] MSG_RING   = 2'd0;
  localparam logic [1:0] MSG_ANSWER = 2'd1;
  localparam logic [1:0] MSG_REJECT = 2'd2;
  localparam logic [1:0] MSG_HANGUP = 2'd3;

endpackage

// File: rtl/call_manager_if.sv
// Signalling port between the call manager and the transport layer.
//   tx_*: outgoing message, single-entry buffer, valid/ready handshake
//   rx_*: incoming message, valid/ready handshake
// master = call manager side, slave = transport side.
interface call_manager_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] tx_type;
  logic [7:0] tx_dst;
  logic       rx_valid;
  logic       rx_ready;
  logic [1:0] rx_type;
  logic [7:0] rx_src;

  modport master (
    output tx_valid, tx_type, tx_dst, rx_ready,
    input  tx_ready, rx_valid, rx_type, rx_src
  );

  modport slave (
    input  tx_valid, tx_type, tx_dst, rx_ready,
    output tx_ready, rx_valid, rx_type, rx_src
  );
endinterface

// File: rtl/call_manager_ring_timer.sv
// Loadable down-counter for the ring/no-answer timeout.
//   load/load_val: reload (wins over en)
//   en:            count down one per cycle, stops at zero
//   expired:       counter currently reads zero
// Stopping at zero keeps expiry asserted so it can wait out a busy TX buffer.
module call_manager_ring_timer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (en && (cnt_q != '0))
      cnt_d = cnt_q - WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/call_manager.sv
// Call-control engine between the UI command channel and the transport.
//   clk, reset        : clock, async active-high reset
//   command, phn_num  : UI command level and dialed address
//   my_addr           : local station address
//   inc_command       : held event code to the UI
//   caller_id         : peer address of current/last call
//   call_active       : high only while connected
//   state             : current call state (debug)
//   net               : transport message port (master side)
// RING_TIMEOUT must be at least 1.
//
// state      | meaning
// IDLE       | no call, waiting for dial or incoming RING
// DIALING    | RING sent, waiting for ANSWER/REJECT or timeout
// RINGING    | RING received, waiting for UI accept/reject or timeout
// CONNECTED  | call up, audio path enabled
module call_manager
  import call_manager_pkg::*;
#(
  parameter int unsigned RING_TIMEOUT = 270_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] command,
  input  logic [7:0] phn_num,
  input  logic [7:0] my_addr,
  output logic [2:0] inc_command,
  output logic [7:0] caller_id,
  output logic       call_active,
  output logic [2:0] state,
  call_manager_if.master net
);

  localparam logic [31:0] TIMER_LOAD = 32'(RING_TIMEOUT - 1);

  call_state_e state_q, state_d;
  logic [2:0]  inc_q, inc_d;
  logic [7:0]  peer_q, peer_d;
  logic        active_q, active_d;
  logic        tx_valid_q, tx_valid_d;
  logic [1:0]  tx_type_q, tx_type_d;
  logic [7:0]  tx_dst_q, tx_dst_d;
  logic [2:0]  cmd_prev_q, cmd_prev_d;
  logic [2:0]  pend_cmd_q, pend_cmd_d;
  logic [7:0]  pend_num_q, pend_num_d;

  logic       ui_edge;
  logic [2:0] ui_cmd;
  logic [7:0] ui_num;
  logic       from_peer;
  logic       timer_load;
  logic       timer_en;
  logic       timer_expired;

  assign from_peer = (net.rx_src == peer_q);
  assign timer_en  = (state_q == ST_DIALING) || (state_q == ST_RINGING);

  call_manager_ring_timer #(.WIDTH(32)) u_ring_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .en       (timer_en),
    .load_val (TIMER_LOAD),
    .expired  (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    inc_d      = inc_q;
    peer_d     = peer_q;
    tx_valid_d = tx_valid_q;
    tx_type_d  = tx_type_q;
    tx_dst_d   = tx_dst_q;
    cmd_prev_d = command;
    timer_load = 1'b0;

    // A fresh edge replaces any older pending command; the pending slot
    // survives until the command is actually evaluated.
    ui_edge    = (command != CMD_NONE) && (command != cmd_prev_q);
    ui_cmd     = ui_edge ? command : pend_cmd_q;
    ui_num     = ui_edge ? phn_num : pend_num_q;
    pend_cmd_d = ui_cmd;
    pend_num_d = ui_num;

    // Every action below may load the TX buffer, so nothing is evaluated
    // until it is empty (this also blocks rx via rx_ready).
    if (tx_valid_q) begin
      if (net.tx_ready) tx_valid_d = 1'b0;
    end else if (net.rx_valid) begin
      if (state_q == ST_IDLE) begin
        if (net.rx_type == MSG_RING) begin
          peer_d     = net.rx_src;
          inc_d      = INC_INCOMING;
          timer_load = 1'b1;
          state_d    = ST_RINGING;
        end
      end else if ((net.rx_type == MSG_RING) && !from_peer) begin
        tx_valid_d = 1'b1;
        tx_type_d  = MSG_REJECT;
        tx_dst_d   = net.rx_src;
      end else if (from_peer) begin
        case (state_q)
          ST_DIALING: begin
            if (net.rx_type == MSG_ANSWER) begin
              state_d = ST_CONNECTED;
              inc_d   = INC_CONNECTED;
            end else if (net.rx_type == MSG_REJECT) begin
              state_d = ST_IDLE;
              inc_d   = INC_REFUSED;
            end
          end
          ST_RINGING, ST_CONNECTED: begin
            if (net.rx_type == MSG_HANGUP) begin
              state_d = ST_IDLE;
              inc_d   = INC_ENDED;
            end
          end
          default: ;
        endcase
      end
    end else if (timer_expired && timer_en) begin
      tx_valid_d = 1'b1;
      tx_dst_d   = peer_q;
      tx_type_d  = (state_q == ST_DIALING) ? MSG_HANGUP : MSG_REJECT;
      state_d    = ST_IDLE;
      inc_d      = INC_NO_ANSWER;
    end else if (ui_cmd != CMD_NONE) begin
      pend_cmd_d = CMD_NONE;
      case (state_q)
        ST_IDLE: begin
          if (ui_cmd == CMD_DIAL) begin
            if (ui_num == my_addr) begin
              inc_d = INC_REFUSED;
            end else begin
              tx_valid_d = 1'b1;
              tx_type_d  = MSG_RING;
              tx_dst_d   = ui_num;
              peer_d     = ui_num;
              inc_d      = INC_NONE;
              timer_load = 1'b1;
              state_d    = ST_DIALING;
            end
          end
        end
        ST_DIALING, ST_CONNECTED: begin
          if (ui_cmd == CMD_END) begin
            tx_valid_d = 1'b1;
            tx_type_d  = MSG_HANGUP;
            tx_dst_d   = peer_q;
            state_d    = ST_IDLE;
            inc_d      = INC_ENDED;
          end
        end
        ST_RINGING: begin
          if (ui_cmd == CMD_ACCEPT) begin
            tx_valid_d = 1'b1;
            tx_type_d  = MSG_ANSWER;
            tx_dst_d   = peer_q;
            state_d    = ST_CONNECTED;
            inc_d      = INC_CONNECTED;
          end else if (ui_cmd == CMD_REJECT) begin
            tx_valid_d = 1'b1;
            tx_type_d  = MSG_REJECT;
            tx_dst_d   = peer_q;
            state_d    = ST_IDLE;
            inc_d      = INC_ENDED;
          end
        end
        default: ;
      endcase
    end

    active_d = (state_d == ST_CONNECTED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      inc_q      <= INC_NONE;
      peer_q     <= 8'h00;
      active_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_type_q  <= MSG_RING;
      tx_dst_q   <= 8'h00;
      cmd_prev_q <= CMD_NONE;
      pend_cmd_q <= CMD_NONE;
      pend_num_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      inc_q      <= inc_d;
      peer_q     <= peer_d;
      active_q   <= active_d;
      tx_valid_q <= tx_valid_d;
      tx_type_q  <= tx_type_d;
      tx_dst_q   <= tx_dst_d;
      cmd_prev_q <= cmd_prev_d;
      pend_cmd_q <= pend_cmd_d;
      pend_num_q <= pend_num_d;
    end
  end

  assign inc_command  = inc_q;
  assign caller_id    = peer_q;
  assign call_active  = active_q;
  assign state        = state_q;
  assign net.tx_valid = tx_valid_q;
  assign net.tx_type  = tx_type_q;
  assign net.tx_dst   = tx_dst_q;
  assign net.rx_ready = !tx_valid_q;

endmodule

// File: tb/tb_call_manager.sv
module tb_call_manager;
  import call_manager_pkg::*;

  localparam int unsigned T  = 20;
  localparam logic [7:0]  MY = 8'h01;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] command;
  logic [7:0] phn_num;
  logic [7:0] my_addr;
  logic [2:0] inc_command;
  logic [7:0] caller_id;
  logic       call_active;
  logic [2:0] state;

  call_manager_if ifc ();

  call_manager #(.RING_TIMEOUT(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .command     (command),
    .phn_num     (phn_num),
    .my_addr     (my_addr),
    .inc_command (inc_command),
    .caller_id   (caller_id),
    .call_active (call_active),
    .state       (state),
    .net         (ifc)
  );

  always #5 clk = ~clk;

  int errors   = 0;
  int checks   = 0;
  int hs_count = 0;
  bit use_model = 1'b0;

  // ---------------- reference model (event level) ----------------
  int          m_state;
  logic [2:0]  m_inc;
  logic [7:0]  m_peer;
  logic [2:0]  m_prev;
  logic [2:0]  m_pcmd;
  logic [7:0]  m_pnum;
  bit          m_txv;
  logic [1:0]  m_txt;
  logic [7:0]  m_txd;
  longint      m_cyc;
  longint      m_deadline;

  task automatic model_reset();
    m_state = 0; m_inc = 0; m_peer = 0; m_prev = 0; m_pcmd = 0; m_pnum = 0;
    m_txv = 0; m_txt = 0; m_txd = 0; m_cyc = 0; m_deadline = 0;
  endtask

  task automatic m_send(input logic [1:0] t, input logic [7:0] d);
    m_txv = 1; m_txt = t; m_txd = d;
  endtask

  task automatic m_goto(input int s, input logic [2:0] inc);
    m_state = s; m_inc = inc;
  endtask

  task automatic model_step();
    logic [1:0] t;
    logic [7:0] s;
    m_cyc++;
    if (command != 0 && command != m_prev) begin
      m_pcmd = command; m_pnum = phn_num;
    end
    m_prev = command;
    t = ifc.rx_type; s = ifc.rx_src;
    if (m_txv) begin
      if (ifc.tx_ready) m_txv = 0;
    end else if (ifc.rx_valid) begin
      if (m_state == 0) begin
        if (t == MSG_RING) begin
          m_peer = s; m_goto(2, 5); m_deadline = m_cyc + T;
        end
      end else if (t == MSG_RING && s != m_peer) m_send(MSG_REJECT, s);
      else if (s == m_peer) begin
        if (m_state == 1 && t == MSG_ANSWER) m_goto(3, 1);
        else if (m_state == 1 && t == MSG_REJECT) m_goto(0, 2);
        else if (m_state >= 2 && t == MSG_HANGUP) m_goto(0, 6);
      end
    end else if ((m_state == 1 || m_state == 2) && m_cyc >= m_deadline) begin
      m_send(m_state == 1 ? MSG_HANGUP : MSG_REJECT, m_peer);
      m_goto(0, 3);
    end else if (m_pcmd != 0) begin
      if (m_state == 0 && m_pcmd == 1) begin
        if (m_pnum == my_addr) m_inc = 2;
        else begin
          m_send(MSG_RING, m_pnum); m_peer = m_pnum; m_goto(1, 0);
          m_deadline = m_cyc + T;
        end
      end else if ((m_state == 1 || m_state == 3) && m_pcmd == 4) begin
        m_send(MSG_HANGUP, m_peer); m_goto(0, 6);
      end else if (m_state == 2 && m_pcmd == 2) begin
        m_send(MSG_ANSWER, m_peer); m_goto(3, 1);
      end else if (m_state == 2 && m_pcmd == 3) begin
        m_send(MSG_REJECT, m_peer); m_goto(0, 6);
      end
      m_pcmd = 0;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string n, input logic [2:0] st, input logic [2:0] inc,
                            input logic [7:0] cid, input logic act, input logic txv,
                            input logic [1:0] txt, input logic [7:0] txd);
    chk({n, ".state"}, 32'(state), 32'(st));
    chk({n, ".inc"}, 32'(inc_command), 32'(inc));
    chk({n, ".caller_id"}, 32'(caller_id), 32'(cid));
    chk({n, ".call_active"}, 32'(call_active), 32'(act));
    chk({n, ".tx_valid"}, 32'(ifc.tx_valid), 32'(txv));
    chk({n, ".rx_ready"}, 32'(ifc.rx_ready), 32'(!txv));
    if (txv) begin
      chk({n, ".tx_type"}, 32'(ifc.tx_type), 32'(txt));
      chk({n, ".tx_dst"}, 32'(ifc.tx_dst), 32'(txd));
    end
  endtask

  task automatic drv(input logic [2:0] c, input logic [7:0] p, input logic rv,
                     input logic [1:0] rt, input logic [7:0] rs, input logic tr);
    command = c; phn_num = p; ifc.rx_valid = rv; ifc.rx_type = rt; ifc.rx_src = rs;
    ifc.tx_ready = tr;
  endtask

  task automatic tick();
    if (ifc.tx_valid && ifc.tx_ready) hs_count++;
    @(posedge clk);
    if (use_model) model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0] cmd; logic [7:0] phn; logic rxv; logic [1:0] rxt; logic [7:0] rxs; logic txr;
    logic [2:0] st; logic [2:0] inc; logic [7:0] cid; logic act; logic txv;
    logic [1:0] txt; logic [7:0] txd;
  } vec_t;

  function automatic vec_t mk(logic [2:0] cmd, logic [7:0] phn, logic rxv, logic [1:0] rxt,
                              logic [7:0] rxs, logic txr, logic [2:0] st, logic [2:0] inc,
                              logic [7:0] cid, logic act, logic txv, logic [1:0] txt,
                              logic [7:0] txd);
    vec_t v;
    v.cmd = cmd; v.phn = phn; v.rxv = rxv; v.rxt = rxt; v.rxs = rxs; v.txr = txr;
    v.st = st; v.inc = inc; v.cid = cid; v.act = act; v.txv = txv; v.txt = txt; v.txd = txd;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int hs0;
    logic [7:0] phns [3];
    logic [7:0] srcs [4];
    phns[0] = MY; phns[1] = 8'h04; phns[2] = 8'h07;
    srcs[0] = 8'h04; srcs[1] = 8'h05; srcs[2] = 8'h07; srcs[3] = 8'h09;

    reset = 1; my_addr = MY;
    drv(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    expect_out("reset", 0, 0, 8'h00, 0, 0, 0, 0);
    reset = 0;

    //          cmd phn  rxv rxt rxs   txr  st inc cid   act txv txt txd
    vecs.push_back(mk(0, 0,    0, 0, 0,     0,   0, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,    1, 0, 8'h07, 0,   2, 5, 8'h07, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,    0, 0, 0,     0,   2, 5, 8'h07, 0, 0, 0, 0));
    vecs.push_back(mk(2, 0,    0, 0, 0,     0,   3, 1, 8'h07, 1, 1, 1, 8'h07));
    vecs.push_back(mk(2, 0,    0, 0, 0,     1,   3, 1, 8'h07, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,    1, 3, 8'h07, 1,   0, 6, 8'h07, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h04, 0, 0, 0,    0,   1, 0, 8'h04, 0, 1, 0, 8'h04));
    vecs.push_back(mk(1, 8'h04, 0, 0, 0,    0,   1, 0, 8'h04, 0, 1, 0, 8'h04));
    vecs.push_back(mk(1, 8'h04, 0, 0, 0,    0,   1, 0, 8'h04, 0, 1, 0, 8'h04));
    vecs.push_back(mk(1, 8'h04, 0, 0, 0,    0,   1, 0, 8'h04, 0, 1, 0, 8'h04));
    vecs.push_back(mk(1, 8'h04, 0, 0, 0,    1,   1, 0, 8'h04, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,    1, 1, 8'h04, 1,   3, 1, 8'h04, 1, 0, 0, 0));
    vecs.push_back(mk(4, 0,    0, 0, 0,     0,   0, 6, 8'h04, 0, 1, 3, 8'h04));
    vecs.push_back(mk(4, 0,    1, 0, 8'h09, 0,   0, 6, 8'h04, 0, 1, 3, 8'h04));
    vecs.push_back(mk(4, 0,    0, 0, 0,     1,   0, 6, 8'h04, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,    0, 0, 0,     1,   0, 6, 8'h04, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drv(vecs[i].cmd, vecs[i].phn, vecs[i].rxv, vecs[i].rxt, vecs[i].rxs, vecs[i].txr);
      tick();
      expect_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].inc, vecs[i].cid, vecs[i].act,
                 vecs[i].txv, vecs[i].txt, vecs[i].txd);
    end

    // No answer: expiry exactly RING_TIMEOUT edges after the dial edge.
    drv(1, 8'h04, 0, 0, 0, 1);
    tick();
    expect_out("noans.dial", 1, 0, 8'h04, 0, 1, MSG_RING, 8'h04);
    for (int i = 1; i < T; i++) begin
      tick();
      chk($sformatf("noans.wait%0d.state", i), 32'(state), 32'd1);
    end
    tick();
    expect_out("noans.expire", 0, 3, 8'h04, 0, 1, MSG_HANGUP, 8'h04);
    drv(0, 8'h04, 0, 0, 0, 1);
    tick();
    tick();
    drv(1, MY, 0, 0, 0, 1);
    tick();
    expect_out("dial_self", 0, 2, 8'h04, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1);
    tick();

    // Busy reject while connected.
    drv(1, 8'h04, 0, 0, 0, 1); tick();
    drv(0, 8'h04, 0, 0, 0, 1); tick();
    drv(0, 0, 1, MSG_ANSWER, 8'h04, 1); tick();
    expect_out("busy.conn", 3, 1, 8'h04, 1, 0, 0, 0);
    drv(0, 0, 1, MSG_RING, 8'h09, 1); tick();
    expect_out("busy.reject", 3, 1, 8'h04, 1, 1, MSG_REJECT, 8'h09);
    drv(0, 0, 0, 0, 0, 1); tick();
    expect_out("busy.drain", 3, 1, 8'h04, 1, 0, 0, 0);
    drv(4, 0, 0, 0, 0, 1); tick();
    expect_out("busy.end", 0, 6, 8'h04, 0, 1, MSG_HANGUP, 8'h04);
    drv(0, 0, 0, 0, 0, 1); tick();

    // Accept colliding with HANGUP: rx wins, accept then ignored in IDLE.
    drv(0, 0, 1, MSG_RING, 8'h07, 1); tick();
    expect_out("sim.ring", 2, 5, 8'h07, 0, 0, 0, 0);
    drv(2, 0, 1, MSG_HANGUP, 8'h07, 1); tick();
    expect_out("sim.collide", 0, 6, 8'h07, 0, 0, 0, 0);
    drv(2, 0, 0, 0, 0, 1); tick();
    expect_out("sim.after", 0, 6, 8'h07, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1); tick();

    // Held accept acts once.
    drv(0, 0, 1, MSG_RING, 8'h07, 1); tick();
    hs0 = hs_count;
    drv(2, 0, 0, 0, 0, 1);
    repeat (10) tick();
    chk("hold.tx_count", 32'(hs_count - hs0), 32'd1);
    expect_out("hold.state", 3, 1, 8'h07, 1, 0, 0, 0);

    // Reset mid-call with a message still pending.
    drv(0, 0, 1, MSG_RING, 8'h09, 0); tick();
    expect_out("rst.pending", 3, 1, 8'h07, 1, 1, MSG_REJECT, 8'h09);
    drv(0, 0, 0, 0, 0, 0);
    #2 reset = 1;
    @(negedge clk);
    expect_out("rst.mid", 0, 0, 8'h00, 0, 0, 0, 0);
    reset = 0;
    drv(0, 0, 0, 0, 0, 1);
    tick();
    expect_out("rst.after", 0, 0, 8'h00, 0, 0, 0, 0);

    // Randomized run against the reference model.
    reset = 1;
    model_reset();
    @(negedge clk);
    reset = 0;
    use_model = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) command = 3'($urandom_range(0, 4));
      phn_num      = phns[$urandom_range(0, 2)];
      ifc.rx_valid = ($urandom_range(0, 3) == 0);
      ifc.rx_type  = 2'($urandom_range(0, 3));
      ifc.rx_src   = srcs[$urandom_range(0, 3)];
      ifc.tx_ready = ($urandom_range(0, 9) < 6);
      tick();
      expect_out($sformatf("rand%0d", i), 3'(m_state), m_inc, m_peer, (m_state == 3),
                 m_txv, m_txt, m_txd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/call_manager.md
# call_manager

Application-layer call-control engine that terminates the UI command channel. It consumes the user interface's `command`/`phn_num` outputs and produces the `inc_command` event stream and caller ID that the UI consumes. Toward the network it exchanges 2-bit signalling messages (RING/ANSWER/REJECT/HANGUP) with a transport layer over a valid/ready transmit port and a valid/ready receive port. It owns call state, the peer address and the ring/no-answer timeout.

## Interface
- `RING_TIMEOUT`, default 270_000_000: ring/no-answer limit in clk cycles (10 s at 27 MHz); 32-bit counter.
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `command`  in  3  UI level: 0 none, 1 dial, 2 accept, 3 reject, 4 end call
- `phn_num`  in  8  dialed address, sampled with a dial command
- `my_addr`  in  8  local station address
- `inc_command`  out  3  event code to UI, held: 0 none, 1 connected, 2 refused/busy, 3 no answer, 5 incoming, 6 call ended
- `caller_id`  out  8  peer address of current/last call
- `call_active`  out  1  high only in CONNECTED; gates audio path
- `state`  out  3  current FSM state (debug)
- `tx_valid`  out  1; `tx_ready`  in  1; `tx_type`  out  2; `tx_dst`  out  8  outgoing message
- `rx_valid`  in  1; `rx_ready`  out  1; `rx_type`  in  2; `rx_src`  in  8  incoming message
- Message types: 0 RING, 1 ANSWER, 2 REJECT, 3 HANGUP.

## Operation
- States: IDLE(0), DIALING(1), RINGING(2), CONNECTED(3).
- A UI command acts once, on the edge where `command` is nonzero and differs from its value sampled on the previous edge. A held level does not retrigger.
- IDLE:
  - dial, `phn_num`≠`my_addr` → send RING to `phn_num`, peer←`phn_num`, `inc_command`←0, load timer, DIALING.
  - dial to self → `inc_command`←2, stay.
  - rx RING → peer/`caller_id`←`rx_src`, `inc_command`←5, load timer, RINGING.
- DIALING:
  - rx ANSWER from peer → CONNECTED, inc 1.
  - rx REJECT from peer → IDLE, inc 2.
  - timer expiry → send HANGUP to peer, IDLE, inc 3.
  - UI end → send HANGUP, IDLE, inc 6.
- RINGING:
  - UI accept → send ANSWER, CONNECTED, inc 1.
  - UI reject → send REJECT, IDLE, inc 6.
  - rx HANGUP from peer → IDLE, inc 6.
  - timer expiry → send REJECT, IDLE, inc 3.
- CONNECTED:
  - UI end → send HANGUP, IDLE, inc 6.
  - rx HANGUP from peer → IDLE, inc 6.
- Any non-IDLE state: rx RING from a non-peer → send REJECT to `rx_src` (busy); state unchanged.
- Other rx messages from non-peers, or of a type not listed for the current state, are consumed and ignored.
- UI commands not listed for the current state are ignored.
- Reset: IDLE, `inc_command`=0, `caller_id`=0, `call_active`=0, `tx_valid`=0, timer cleared, sampled command=0. Reset mid-call sends no HANGUP.

## Timing
- All outputs are registered. Effects of an rx accept or UI edge at clock edge N are visible after edge N (state, inc, tx_valid).
- TX is a single-entry buffer. `tx_valid`/`tx_type`/`tx_dst` are held stable until the cycle `tx_valid`&`tx_ready`.
- `rx_ready` = !`tx_valid`. An rx transfer occurs when `rx_valid`&`rx_ready`.
- While `tx_valid` is high, UI edges stay pending (latched) and timer expiry is held pending. Both are acted on in the first cycle the buffer is empty.
- Priority in one cycle: rx transfer > timer expiry > UI command. A losing UI edge is re-evaluated next cycle in the new state. Example: accept coinciding with HANGUP yields IDLE, inc 6, and the accept is then ignored.
- Timer loads `RING_TIMEOUT`-1 and decrements each cycle in DIALING/RINGING. Expiry is the cycle it reads 0 while still in that state.

## Structure
- `call_pkg`: command codes, inc_command codes, message type codes, state enum.
- Sub-module `ring_timer`: loadable 32-bit down-counter with load/enable inputs and a `expired` output.

## Test plan
- Incoming call, `RING_TIMEOUT`=20:
  - rx RING src 0x07 → inc 5, `caller_id` 0x07, state 2.
  - command 2 → tx ANSWER dst 0x07, inc 1, `call_active` 1.
  - rx HANGUP src 0x07 → inc 6, state 0.
- Outgoing call:
  - command 1, `phn_num` 0x04 → tx RING dst 0x04 (`tx_ready` held low 3 cycles, fields stable), inc 0.
  - rx ANSWER src 0x04 → inc 1.
  - command 4 → tx HANGUP, inc 6.
- No answer: dial 0x04, no reply for 20 cycles → tx HANGUP, inc 3, state 0. Dial self (`phn_num`=`my_addr`) → inc 2, no tx.
- Busy: in CONNECTED with 0x04, rx RING src 0x09 → tx REJECT dst 0x09; state, inc and `caller_id` unchanged.
- Simultaneous events: in RINGING, accept and rx HANGUP on the same edge → inc 6, IDLE, no ANSWER sent. Holding command 2 for 10 cycles → exactly one action.
- Reset mid-CONNECTED → all outputs at reset values the next cycle, no tx.
